// File: rtl/nonce_buffer.sv
// Nonce buffer: queues winning nonces in a DEPTH-entry FIFO and streams them out LSB first, one bit per txReady.
// Latency: a write into an empty, idle buffer shows txValid one edge after the FIFO write. Words run back-to-back while nonces are queued.
// Backpressure: txReady=0 stalls the shifter, and a write to a full FIFO with no pop is dropped and sets the sticky overflow flag.
// Optional: define NONCE_BUFFER_DROP_COUNT_EN to add the saturating 8-bit dropCount output.
module nonce_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        newBlock,
  input  logic        wrValid,
  input  logic [31:0] wrNonce,
  input  logic        txReady,
  output logic        txValid,
  output logic        txBit,
  output logic        overflow,
  output logic        empty
`ifdef NONCE_BUFFER_DROP_COUNT_EN
  ,
  output logic [7:0]  dropCount
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  state_t        state_q, state_d;
  logic [31:0]   shift_q, shift_d;
  logic [4:0]    idx_q, idx_d;
  logic          overflow_q, overflow_d;

  logic fifo_full;
  logic fifo_nempty;
  logic pop;
  logic push;
  logic drop;

  assign fifo_full   = (count_q == FULL_CNT);
  assign fifo_nempty = (count_q != '0);

  // Transmit FSM: load from FIFO head when idle or when the last bit of a word is accepted.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_nempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (txReady) begin
          if (idx_q == 5'd31) begin
            idx_d = '0;
            if (fifo_nempty) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
            end else begin
              shift_d = shift_q >> 1;
              state_d = IDLE;
            end
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A new block makes everything stale: abort the word and stop popping.
    if (newBlock) begin
      state_d = IDLE;
      idx_d   = '0;
      pop     = 1'b0;
    end
  end

  // FIFO bookkeeping: a full FIFO still accepts a write when the same edge pops.
  always_comb begin
    push       = wrValid && !newBlock && (!fifo_full || pop);
    drop       = wrValid && !newBlock && fifo_full && !pop;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    overflow_d = overflow_q | drop;
    if (newBlock) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  // Storage array; no reset needed since entries are only read behind the count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= wrNonce;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef NONCE_BUFFER_DROP_COUNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter, cleared together with the overflow flag.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (newBlock) begin
      drop_cnt_d = '0;
    end else if (drop && drop_cnt_q != 8'hFF) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign dropCount = drop_cnt_q;
`endif

  // txBit is gated so an aborted word never leaks a stale bit.
  assign txValid  = (state_q == SHIFT);
  assign txBit    = (state_q == SHIFT) & shift_q[0];
  assign overflow = overflow_q;
  assign empty    = (count_q == '0) && (state_q == IDLE);

endmodule

// File: tb/tb_nonce_buffer.sv
module tb_nonce_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        newBlock;
  logic        wrValid;
  logic [31:0] wrNonce;
  logic        txReady;
  logic        txValid;
  logic        txBit;
  logic        overflow;
  logic        empty;
`ifdef NONCE_BUFFER_DROP_COUNT_EN
  logic [7:0]  dropCount;
`endif

  always #5 clk = ~clk;

  nonce_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .newBlock (newBlock),
    .wrValid  (wrValid),
    .wrNonce  (wrNonce),
    .txReady  (txReady),
    .txValid  (txValid),
    .txBit    (txBit),
    .overflow (overflow),
    .empty    (empty)
`ifdef NONCE_BUFFER_DROP_COUNT_EN
    ,
    .dropCount(dropCount)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending nonces plus the word in flight and how many of its bits went out.
  logic [31:0] mq[$];
  bit          m_busy = 1'b0;
  logic [31:0] m_cur  = '0;
  int          m_nbits = 0;
  bit          m_ovf  = 1'b0;
  int          m_drops = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin : mdl
    int sz;
    bit pp;
    if (rst) begin
      mq.delete();
      m_busy = 0; m_cur = '0; m_nbits = 0; m_ovf = 0; m_drops = 0;
      chk_en = 1;
    end else if (newBlock) begin
      mq.delete();
      m_busy = 0; m_nbits = 0; m_ovf = 0; m_drops = 0;
    end else begin
      sz = mq.size();
      pp = (sz > 0) && (!m_busy || (txReady && m_nbits == 31));
      if (wrValid && (sz - int'(pp)) >= DEPTH) begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
      if (m_busy && txReady) begin
        if (m_nbits == 31) m_busy = 0;
        else m_nbits++;
      end
      if (pp) begin
        m_cur = mq.pop_front();
        m_nbits = 0;
        m_busy = 1;
      end
      if (wrValid && (sz - int'(pp)) < DEPTH) mq.push_back(wrNonce);
    end
  end

  // Stream monitor state.
  bit acc[$];
  int vcnt = 0;
  int run = 0;
  int maxrun = 0;

  // Per-cycle compare against the model, plus capture of accepted bits.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("txValid", 32'(txValid), 32'(m_busy));
      chk("txBit", 32'(txBit), 32'(m_busy ? m_cur[m_nbits] : 1'b0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("empty", 32'(empty), 32'((mq.size() == 0) && !m_busy));
`ifdef NONCE_BUFFER_DROP_COUNT_EN
      chk("dropCount", 32'(dropCount), 32'(m_drops));
`endif
      if (txValid === 1'b1 && txReady === 1'b1) acc.push_back(txBit);
      if (txValid === 1'b1) begin
        vcnt++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    acc.delete();
    vcnt = 0; run = 0; maxrun = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic write(input logic [31:0] n);
    wrValid = 1'b1;
    wrNonce = n;
    step(1);
    wrValid = 1'b0;
  endtask

  function automatic logic [31:0] acc_word(input int w);
    logic [31:0] r;
    if (acc.size() < (w + 1) * 32) return 'x;
    for (int i = 0; i < 32; i++) r[i] = acc[w * 32 + i];
    return r;
  endfunction

  initial begin
    rst = 1'b1; newBlock = 1'b0; wrValid = 1'b0; wrNonce = '0; txReady = 1'b0;
    step(2);
    rst = 1'b0;
    chk("rst_txValid", 32'(txValid), 32'd0);
    chk("rst_txBit", 32'(txBit), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);

    // Single word, always ready.
    clear_mon();
    txReady = 1'b1;
    write(32'hA5A5_0001);
    chk("lat_write_edge", 32'(txValid), 32'd0);
    step(1);
    chk("lat_load_edge", 32'(txValid), 32'd1);
    step(39);
    chk("single_vcnt", 32'(vcnt), 32'd32);
    chk("single_run", 32'(maxrun), 32'd32);
    chk("single_word", acc_word(0), 32'hA5A5_0001);
    chk("single_first", 32'(acc[0]), 32'd1);
    chk("single_last", 32'(acc[31]), 32'd1);
    chk("single_empty", 32'(empty), 32'd1);

    // Two words back to back.
    clear_mon();
    write(32'h0000_0001);
    write(32'h8000_0000);
    step(75);
    chk("b2b_vcnt", 32'(vcnt), 32'd64);
    chk("b2b_run", 32'(maxrun), 32'd64);
    chk("b2b_first", 32'(acc[0]), 32'd1);
    chk("b2b_last", 32'(acc[63]), 32'd1);
    chk("b2b_w0", acc_word(0), 32'h0000_0001);
    chk("b2b_w1", acc_word(1), 32'h8000_0000);

    // Overflow: ten writes while stalled.
    do_reset();
    clear_mon();
    txReady = 1'b0;
    for (int i = 0; i < 10; i++) write(32'h1000_0000 + 32'(i));
    step(1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(dut.count_q), 32'd8);
`ifdef NONCE_BUFFER_DROP_COUNT_EN
    chk("ovf_dropCount", 32'(dropCount), 32'd1);
`endif
    newBlock = 1'b1;
    step(1);
    newBlock = 1'b0;
    chk("nb_ovf_clear", 32'(overflow), 32'd0);
    chk("nb_empty", 32'(empty), 32'd1);
`ifdef NONCE_BUFFER_DROP_COUNT_EN
    chk("nb_dropCount", 32'(dropCount), 32'd0);
`endif

    // newBlock at bit 10 with three nonces queued and a simultaneous write.
    clear_mon();
    txReady = 1'b0;
    for (int i = 0; i < 4; i++) write(32'h2000_0000 + 32'(i));
    txReady = 1'b1;
    step(10);
    chk("abort_bits_before", 32'(acc.size()), 32'd10);
    txReady = 1'b0;
    newBlock = 1'b1;
    wrValid = 1'b1;
    wrNonce = 32'hDEAD_BEEF;
    step(1);
    newBlock = 1'b0;
    wrValid = 1'b0;
    chk("abort_txValid", 32'(txValid), 32'd0);
    chk("abort_empty", 32'(empty), 32'd1);
    chk("abort_overflow", 32'(overflow), 32'd0);
    txReady = 1'b1;
    step(40);
    chk("abort_no_more", 32'(acc.size()), 32'd10);

    // Reset in the middle of a word.
    clear_mon();
    write(32'h1234_5678);
    step(6);
    do_reset();
    chk("mrst_txValid", 32'(txValid), 32'd0);
    chk("mrst_txBit", 32'(txBit), 32'd0);
    chk("mrst_empty", 32'(empty), 32'd1);
    clear_mon();
    step(40);
    chk("mrst_no_more", 32'(acc.size()), 32'd0);

    // Alternating ready.
    clear_mon();
    txReady = 1'b1;
    write(32'hFFFF_0000);
    for (int i = 0; i < 80; i++) begin
      txReady = (i % 2 == 0);
      step(1);
    end
    txReady = 1'b1;
    step(5);
    chk("stall_bits", 32'(acc.size()), 32'd32);
    chk("stall_word", acc_word(0), 32'hFFFF_0000);
    chk("stall_vcnt", 32'(vcnt), 32'd64);

    // Full FIFO: pop and write on the same edge.
    do_reset();
    clear_mon();
    txReady = 1'b0;
    for (int i = 0; i < 9; i++) write(32'h3000_0000 + 32'(i));
    chk("full_count", 32'(dut.count_q), 32'd8);
    txReady = 1'b1;
    step(31);
    write(32'hCAFE_0035);
    chk("popwr_count", 32'(dut.count_q), 32'd8);
    chk("popwr_overflow", 32'(overflow), 32'd0);
    step(300);
    chk("popwr_bits", 32'(acc.size()), 32'd320);
    chk("popwr_w0", acc_word(0), 32'h3000_0000);
    chk("popwr_w9", acc_word(9), 32'hCAFE_0035);
    chk("popwr_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
